// File: rtl/tds_event_builder_if.sv
// Framed output stream of the TDS event builder:
// valid/ready handshake plus an end-of-event marker.
interface tds_event_builder_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_last;

  modport master (
    output dout,
    output dout_valid,
    output dout_last,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    input  dout_last,
    output dout_ready
  );
endinterface

// File: rtl/tds_event_builder.sv
// tds_event_builder: buffers TDS words while trigger is high, then emits header + words.
// Define TDS_EVT_TRAILER_EN to append a trailer word (word count + XOR checksum).
module tds_event_builder #(
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trigger,
  input  logic                enable,
  input  logic [DATA_W-1:0]   din,
  input  logic                din_valid,
  tds_event_builder_if.master dout_if,
  output logic [15:0]         event_id,
  output logic [15:0]         lost_count,
  output logic [15:0]         drop_count,
  output logic                busy
);
  localparam logic [7:0] CAP = 8'(MAX_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    HEADER,
`ifdef TDS_EVT_TRAILER_EN
    DRAIN,
    TRAILER
`else
    DRAIN
`endif
  } state_t;

  state_t state, state_nxt;

  logic              trig_d;
  logic [7:0]        wcnt;
  logic [7:0]        rd_ptr, rd_nxt;
  logic              trunc;
  logic [DATA_W-1:0] mem [MAX_WORDS+1];
  logic [DATA_W-1:0] dout_q, dout_nxt;
  logic              valid_q, valid_nxt;
  logic              last_q, last_nxt;
  logic              rise, fall, xfer;
  logic              accept, capture, full, done;

`ifdef TDS_EVT_TRAILER_EN
  logic [15:0]       xsum;
  logic [DATA_W-1:0] trailer_w;
  assign trailer_w = {8'hE0, wcnt, xsum};
`endif

  assign rise    = trigger & ~trig_d;
  assign fall    = ~trigger & trig_d;
  assign xfer    = valid_q & dout_if.dout_ready;
  assign accept  = (state == IDLE) & rise & enable;
  assign capture = din_valid & trigger &
                   (accept | (state == COLLECT));
  assign full    = (wcnt == CAP);
  assign busy    = (state != IDLE);

  assign dout_if.dout       = dout_q;
  assign dout_if.dout_valid = valid_q;
  assign dout_if.dout_last  = last_q;

  // Capture buffer; no reset, occupancy is tracked by wcnt.
  always_ff @(posedge clk) begin
    if (capture && !full) mem[wcnt] <= din;
  end

  // Edge detector, word count, truncation flag and status counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_d     <= 1'b0;
      wcnt       <= 8'd0;
      trunc      <= 1'b0;
      event_id   <= 16'd0;
      lost_count <= 16'd0;
      drop_count <= 16'd0;
`ifdef TDS_EVT_TRAILER_EN
      xsum       <= 16'd0;
`endif
    end else begin
      trig_d <= trigger;
      if (done) begin
        wcnt  <= 8'd0;
        trunc <= 1'b0;
`ifdef TDS_EVT_TRAILER_EN
        xsum  <= 16'd0;
`endif
      end else if (capture) begin
        if (full) begin
          trunc <= 1'b1;
          if (drop_count != 16'hFFFF)
            drop_count <= drop_count + 16'd1;
        end else begin
          wcnt <= wcnt + 8'd1;
`ifdef TDS_EVT_TRAILER_EN
          xsum <= xsum ^ din[31:16] ^ din[15:0];
`endif
        end
      end
      if (state == HEADER && xfer)
        event_id <= event_id + 16'd1;
      if (rise && !(state inside {IDLE, COLLECT}) &&
          lost_count != 16'hFFFF)
        lost_count <= lost_count + 16'd1;
    end
  end

  // State and registered output word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      dout_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      rd_ptr  <= 8'd0;
    end else begin
      state   <= state_nxt;
      dout_q  <= dout_nxt;
      valid_q <= valid_nxt;
      last_q  <= last_nxt;
      rd_ptr  <= rd_nxt;
    end
  end

  // Next state and next output word; outputs only change on a transfer.
  always_comb begin
    state_nxt = state;
    dout_nxt  = dout_q;
    valid_nxt = valid_q;
    last_nxt  = last_q;
    rd_nxt    = rd_ptr;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = COLLECT;
      end
      COLLECT: begin
        if (fall) begin
          state_nxt = HEADER;
          dout_nxt  = {4'hA, trunc, 3'b000, wcnt, event_id};
          valid_nxt = 1'b1;
`ifdef TDS_EVT_TRAILER_EN
          last_nxt  = 1'b0;
`else
          last_nxt  = (wcnt == 8'd0);
`endif
        end
      end
      HEADER, DRAIN: begin
        if (xfer) begin
          if (rd_ptr == wcnt) begin
`ifdef TDS_EVT_TRAILER_EN
            state_nxt = TRAILER;
            dout_nxt  = trailer_w;
            last_nxt  = 1'b1;
`else
            state_nxt = IDLE;
            valid_nxt = 1'b0;
            last_nxt  = 1'b0;
            rd_nxt    = 8'd0;
            done      = 1'b1;
`endif
          end else begin
            state_nxt = DRAIN;
            dout_nxt  = mem[rd_ptr];
            rd_nxt    = rd_ptr + 8'd1;
`ifdef TDS_EVT_TRAILER_EN
            last_nxt  = 1'b0;
`else
            last_nxt  = (rd_ptr == wcnt - 8'd1);
`endif
          end
        end
      end
`ifdef TDS_EVT_TRAILER_EN
      TRAILER: begin
        if (xfer) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
          last_nxt  = 1'b0;
          rd_nxt    = 8'd0;
          done      = 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_tds_event_builder.sv
// Bench for tds_event_builder: random windows against a queue model
// of the framed event (header, stored words, optional trailer).
`timescale 1ns/1ps
module tb_tds_event_builder;
  localparam int MAXW = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trigger = 1'b0;
  logic        enable = 1'b1;
  logic        din_valid = 1'b0;
  logic [31:0] din = '0;
  logic [15:0] event_id, lost_count, drop_count;
  logic        busy;

  tds_event_builder_if #(.DATA_W(32)) bus ();

  tds_event_builder #(.DATA_W(32), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .enable(enable),
    .din(din), .din_valid(din_valid), .dout_if(bus),
    .event_id(event_id), .lost_count(lost_count),
    .drop_count(drop_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passed = 0;
  logic [31:0] exp_w[$], got_w[$], fixw[$];
  bit          got_l[$];
  logic [15:0] exp_id = '0, exp_lost = '0, exp_drop = '0;
  bit          tmo;
  int          stall_bad;

  // Model: the event as the sink should see it.
  function automatic void build_exp(input logic [31:0] st[$], input bit tr);
    exp_w.delete();
    exp_w.push_back({4'hA, tr, 3'b000, 8'(st.size()), exp_id});
    foreach (st[i]) exp_w.push_back(st[i]);
`ifdef TDS_EVT_TRAILER_EN
    begin
      logic [15:0] x;
      x = '0;
      foreach (st[i]) x = x ^ st[i][31:16] ^ st[i][15:0];
      exp_w.push_back({8'hE0, 8'(st.size()), x});
    end
`endif
    exp_id = exp_id + 16'd1;
  endfunction

  task automatic run_window(input int len, input int vpct, input bit en);
    logic [31:0] st[$];
    int nd;
    nd = 0;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      trigger = 1'b1;
      enable = en;
      if (c < fixw.size()) begin
        din = fixw[c];
        din_valid = 1'b1;
      end else begin
        din = $urandom;
        din_valid = ($urandom_range(99, 0) < vpct);
      end
      if (din_valid) begin
        if (st.size() < MAXW) st.push_back(din);
        else nd++;
      end
    end
    @(negedge clk);
    trigger = 1'b0;
    din_valid = 1'b0;
    din = '0;
    enable = 1'b1;
    if (en) begin
      build_exp(st, nd > 0);
      if (int'(exp_drop) + nd > 65535) exp_drop = 16'hFFFF;
      else exp_drop = exp_drop + 16'(nd);
    end
  endtask

  task automatic collect(input bit rnd, input int trig_at,
                         output bit to, output int sb);
    logic [31:0] pd;
    logic pl;
    bit ps;
    got_w.delete();
    got_l.delete();
    to = 1'b1;
    sb = 0;
    ps = 1'b0;
    pd = '0;
    pl = 1'b0;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      if (c == trig_at) trigger = 1'b1;
      if (c == trig_at + 1) trigger = 1'b0;
      bus.dout_ready = rnd ? (($urandom % 2) == 1) : 1'b1;
      if (ps && (!bus.dout_valid || bus.dout !== pd || bus.dout_last !== pl))
        sb++;
      ps = bus.dout_valid && !bus.dout_ready;
      pd = bus.dout;
      pl = bus.dout_last;
      if (bus.dout_valid && bus.dout_ready) begin
        got_w.push_back(bus.dout);
        got_l.push_back(bus.dout_last);
        if (bus.dout_last) begin
          to = 1'b0;
          break;
        end
      end
    end
    trigger = 1'b0;
    bus.dout_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.dout_valid, bus.dout_last, busy} !== 3'b000)
      $display("FAIL reset_flags: got %b, want 000", {bus.dout_valid, bus.dout_last, busy});
    else passed++;
    checks++;
    if (bus.dout !== 32'd0)
      $display("FAIL reset_dout: got %h, want 00000000", bus.dout);
    else passed++;
    checks++;
    if ({event_id, lost_count, drop_count} !== 48'd0)
      $display("FAIL reset_counters: got %h, want 0", {event_id, lost_count, drop_count});
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.dout_valid !== 1'b0)
      $display("FAIL post_reset_idle: busy %b valid %b, want 0 0", busy, bus.dout_valid);
    else passed++;
  endtask

  task automatic test_basic();
    fixw = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    run_window(4, 0, 1'b1);
    fixw.delete();
    collect(1'b0, -1, tmo, stall_bad);
    checks++;
    if (tmo || got_w.size() != exp_w.size())
      $display("FAIL basic_len: got %0d (timeout %0b), want %0d", got_w.size(), tmo, exp_w.size());
    else passed++;
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_l[i] !== (i == exp_w.size() - 1))
        $display("FAIL basic_word[%0d]: got %h/%0b, want %h/%0b", i, got_w[i], got_l[i], exp_w[i], i == exp_w.size() - 1);
      else passed++;
    end
    checks++;
    if (got_w.size() == 0 || got_w[0] !== 32'hA0040000)
      $display("FAIL basic_header: got %h, want a0040000", got_w.size() ? got_w[0] : 32'hx);
    else passed++;
    @(negedge clk);
    checks++;
    if (event_id !== exp_id || busy !== 1'b0)
      $display("FAIL basic_after: event_id %h busy %b, want %h 0", event_id, busy, exp_id);
    else passed++;
  endtask

  task automatic test_empty();
    run_window(3, 0, 1'b1);
    collect(1'b0, -1, tmo, stall_bad);
    checks++;
    if (tmo || got_w.size() != 1)
      $display("FAIL empty_len: got %0d (timeout %0b), want 1", got_w.size(), tmo);
    else passed++;
    checks++;
    if (got_w.size() == 0 || got_w[0] !== exp_w[0] || got_l[0] !== 1'b1)
      $display("FAIL empty_header: got %h, want %h with last", got_w.size() ? got_w[0] : 32'hx, exp_w[0]);
    else passed++;
  endtask

  task automatic test_cap();
    run_window(300, 100, 1'b1);
    collect(1'b0, -1, tmo, stall_bad);
    checks++;
    if (tmo || got_w.size() != exp_w.size())
      $display("FAIL cap_len: got %0d (timeout %0b), want %0d", got_w.size(), tmo, exp_w.size());
    else passed++;
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_l[i] !== (i == exp_w.size() - 1))
        $display("FAIL cap_word[%0d]: got %h/%0b, want %h/%0b", i, got_w[i], got_l[i], exp_w[i], i == exp_w.size() - 1);
      else passed++;
    end
    checks++;
    if (drop_count !== exp_drop)
      $display("FAIL cap_drop: got %0d, want %0d", drop_count, exp_drop);
    else passed++;
  endtask

  task automatic test_lost_backpressure();
    run_window(9, 100, 1'b1);
    exp_lost = exp_lost + 16'd1;
    collect(1'b1, 3, tmo, stall_bad);
    checks++;
    if (tmo || got_w.size() != exp_w.size())
      $display("FAIL bp_len: got %0d (timeout %0b), want %0d", got_w.size(), tmo, exp_w.size());
    else passed++;
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_l[i] !== (i == exp_w.size() - 1))
        $display("FAIL bp_word[%0d]: got %h/%0b, want %h/%0b", i, got_w[i], got_l[i], exp_w[i], i == exp_w.size() - 1);
      else passed++;
    end
    checks++;
    if (stall_bad != 0)
      $display("FAIL bp_stall: got %0d unstable stalls, want 0", stall_bad);
    else passed++;
    @(negedge clk);
    checks++;
    if (lost_count !== exp_lost || busy !== 1'b0)
      $display("FAIL bp_lost: lost %0d busy %b, want %0d 0", lost_count, busy, exp_lost);
    else passed++;
  endtask

  task automatic test_back_to_back();
    bit en;
    for (int e = 0; e < 25; e++) begin
      en = ($urandom_range(9, 0) != 0);
      run_window($urandom_range(15, 1), 60, en);
      if (en) begin
        collect(1'b1, -1, tmo, stall_bad);
        checks++;
        if (tmo || got_w.size() != exp_w.size() || stall_bad != 0)
          $display("FAIL b2b_len[%0d]: got %0d (timeout %0b stalls %0d), want %0d", e, got_w.size(), tmo, stall_bad, exp_w.size());
        else passed++;
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
          checks++;
          if (got_w[i] !== exp_w[i] || got_l[i] !== (i == exp_w.size() - 1))
            $display("FAIL b2b_word[%0d.%0d]: got %h/%0b, want %h/%0b", e, i, got_w[i], got_l[i], exp_w[i], i == exp_w.size() - 1);
          else passed++;
        end
      end else begin
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus.dout_valid !== 1'b0)
          $display("FAIL b2b_disabled[%0d]: busy %b valid %b, want 0 0", e, busy, bus.dout_valid);
        else passed++;
      end
    end
    checks++;
    if ({event_id, lost_count, drop_count} !== {exp_id, exp_lost, exp_drop})
      $display("FAIL b2b_counters: got %h/%h/%h, want %h/%h/%h", event_id, lost_count, drop_count, exp_id, exp_lost, exp_drop);
    else passed++;
  endtask

`ifdef TDS_EVT_TRAILER_EN
  task automatic test_trailer();
    fixw = '{32'h00010002, 32'h00040008};
    run_window(2, 0, 1'b1);
    fixw.delete();
    collect(1'b0, -1, tmo, stall_bad);
    checks++;
    if (tmo || got_w.size() != exp_w.size())
      $display("FAIL trl_len: got %0d (timeout %0b), want %0d", got_w.size(), tmo, exp_w.size());
    else passed++;
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_l[i] !== (i == exp_w.size() - 1))
        $display("FAIL trl_word[%0d]: got %h/%0b, want %h/%0b", i, got_w[i], got_l[i], exp_w[i], i == exp_w.size() - 1);
      else passed++;
    end
    checks++;
    if (got_w.size() == 0 || got_w[got_w.size() - 1] !== 32'hE002000F)
      $display("FAIL trl_word: got %h, want e002000f", got_w.size() ? got_w[got_w.size() - 1] : 32'hx);
    else passed++;
  endtask
`endif

  task automatic test_reset_mid();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      trigger = 1'b1;
      din = $urandom;
      din_valid = 1'b1;
    end
    @(negedge clk);
    din_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.dout_valid, bus.dout_last, busy} !== 3'b000 || bus.dout !== 32'd0)
      $display("FAIL rstmid_out: got %b %h, want 000 00000000", {bus.dout_valid, bus.dout_last, busy}, bus.dout);
    else passed++;
    checks++;
    if ({event_id, lost_count, drop_count} !== 48'd0)
      $display("FAIL rstmid_counters: got %h, want 0", {event_id, lost_count, drop_count});
    else passed++;
    @(negedge clk);
    trigger = 1'b0;
    rst = 1'b0;
    exp_id = '0;
    exp_lost = '0;
    exp_drop = '0;
    run_window(5, 100, 1'b1);
    collect(1'b0, -1, tmo, stall_bad);
    checks++;
    if (tmo || got_w.size() != exp_w.size())
      $display("FAIL rstmid_len: got %0d (timeout %0b), want %0d", got_w.size(), tmo, exp_w.size());
    else passed++;
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_l[i] !== (i == exp_w.size() - 1))
        $display("FAIL rstmid_word[%0d]: got %h/%0b, want %h/%0b", i, got_w[i], got_l[i], exp_w[i], i == exp_w.size() - 1);
      else passed++;
    end
  endtask

  initial begin
    bus.dout_ready = 1'b1;
    test_reset();
    test_basic();
    test_empty();
    test_cap();
    test_lost_backpressure();
    test_back_to_back();
`ifdef TDS_EVT_TRAILER_EN
    test_trailer();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
